// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, class encodings and helpers for the unpack/normalize block.
package fp32_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = 24;
  localparam int unsigned OEXP_W  = 10;
  localparam int unsigned CLASS_W = 3;
  localparam int unsigned LZC_W   = 5;

  localparam int FP32_BIAS  = 127;
  localparam int EXP_INFNAN = 128;
  localparam int EXP_SUBN   = -126;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ZERO = 3'd0,
    CLS_SUBN = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } norm_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Leading-zero count of a significand; returns MANT_W for an all-zero input.
  function automatic logic [LZC_W-1:0] lzc_mant(input logic [MANT_W-1:0] m);
    logic [LZC_W-1:0] n;
    logic             found;
    n     = LZC_W'(MANT_W);
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && m[i]) begin
        n     = LZC_W'(int'(MANT_W) - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_class_decode.sv
// Combinational split of an FP32 word into sign/exponent/fraction fields plus class.
module fp32_class_decode
  import fp32_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output fp_class_e         class_c,
  output logic              sign_c,
  output logic [EXP_W-1:0]  exp_field_c,
  output logic [FRAC_W-1:0] frac_field_c
);

  fp32_t f;

  assign f            = fp32_t'(word);
  assign sign_c       = f.sign;
  assign exp_field_c  = f.exp;
  assign frac_field_c = f.frac;

  // All-ones exponent is inf/NaN; fraction MSB separates quiet from signalling NaN.
  always_comb begin
    class_c = CLS_NORM;
    if (f.exp == '0) begin
      class_c = (f.frac == '0) ? CLS_ZERO : CLS_SUBN;
    end else if (f.exp == '1) begin
      if (f.frac == '0) begin
        class_c = CLS_INF;
      end else begin
        class_c = f.frac[FRAC_W-1] ? CLS_QNAN : CLS_SNAN;
      end
    end
  end

endmodule

// File: rtl/fp32_unpack_norm.sv
// FP32 unpacker: classifies an operand and normalizes subnormals by iterative left shift.
// Define FP32_UNPACK_DAZ_EN to flush subnormals to zero instead of normalizing them.
module fp32_unpack_norm
  import fp32_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [OEXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0]  out_mant,
  output logic [CLASS_W-1:0] out_class
);

  localparam logic [LZC_W-1:0] STEP = LZC_W'(SHIFT_STEP);

  norm_state_e       state, state_n;
  fp_class_e         class_r, class_n;
  logic              in_ready_n, out_valid_n, sign_n;
  logic [OEXP_W-1:0] exp_n;
  logic [MANT_W-1:0] mant_n;

  fp_class_e         dec_class_c;
  logic              dec_sign_c;
  logic [EXP_W-1:0]  dec_exp_c;
  logic [FRAC_W-1:0] dec_frac_c;

  logic [LZC_W-1:0]  lz_c, sh_c;
  logic [MANT_W-1:0] shifted_c;

  fp32_class_decode u_decode (
    .word         (in_data),
    .class_c      (dec_class_c),
    .sign_c       (dec_sign_c),
    .exp_field_c  (dec_exp_c),
    .frac_field_c (dec_frac_c)
  );

  // One normalization step: shift by at most STEP, never past the leading one.
  assign lz_c      = lzc_mant(out_mant);
  assign sh_c      = (lz_c < STEP) ? lz_c : STEP;
  assign shifted_c = out_mant << sh_c;
  assign out_class = CLASS_W'(class_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      class_r   <= CLS_ZERO;
    end else begin
      state     <= state_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_sign  <= sign_n;
      out_exp   <= exp_n;
      out_mant  <= mant_n;
      class_r   <= class_n;
    end
  end

  always_comb begin
    state_n = state;
    sign_n  = out_sign;
    exp_n   = out_exp;
    mant_n  = out_mant;
    class_n = class_r;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_n  = dec_sign_c;
          class_n = dec_class_c;
          state_n = HOLD;
          case (dec_class_c)
            CLS_NORM: begin
              exp_n  = OEXP_W'(dec_exp_c) - OEXP_W'(FP32_BIAS);
              mant_n = {1'b1, dec_frac_c};
            end
            CLS_INF, CLS_QNAN, CLS_SNAN: begin
              exp_n  = OEXP_W'(EXP_INFNAN);
              mant_n = {1'b0, dec_frac_c};
            end
            CLS_SUBN: begin
`ifdef FP32_UNPACK_DAZ_EN
              class_n = CLS_ZERO;
              exp_n   = '0;
              mant_n  = '0;
`else
              exp_n   = OEXP_W'(EXP_SUBN);
              mant_n  = {1'b0, dec_frac_c};
              state_n = NORM;
`endif
            end
            default: begin
              exp_n  = '0;
              mant_n = '0;
            end
          endcase
        end
      end
      NORM: begin
        mant_n = shifted_c;
        exp_n  = out_exp - OEXP_W'(sh_c);
        if (shifted_c[MANT_W-1]) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == HOLD);
  end

endmodule

// File: tb/tb_fp32_unpack_norm.sv
// Directed bench for fp32_unpack_norm; runs SHIFT_STEP=1 and SHIFT_STEP=8 instances side by side.
module tb_fp32_unpack_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, out_sign1;
  logic [9:0]  out_exp1;
  logic [23:0] out_mant1;
  logic [2:0]  out_class1;
  logic        in_ready8, out_valid8, out_sign8;
  logic [9:0]  out_exp8;
  logic [23:0] out_mant8;
  logic [2:0]  out_class8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          sign;
    int          exp_v;
    int          mant;
    int          cls;
    int          lat1;
    int          lat8;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  fp32_unpack_norm #(.SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sign(out_sign1), .out_exp(out_exp1),
    .out_mant(out_mant1), .out_class(out_class1)
  );

  fp32_unpack_norm #(.SHIFT_STEP(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sign(out_sign8), .out_exp(out_exp8),
    .out_mant(out_mant8), .out_class(out_class8)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic [9:0] e, input logic [23:0] m,
                         input logic [2:0] c, input vec_t v);
    chk($sformatf("%s %h sign", tag, v.data), 32'(s), 32'(v.sign));
    chk($sformatf("%s %h exp", tag, v.data), 32'($signed(e)), 32'(v.exp_v));
    chk($sformatf("%s %h mant", tag, v.data), 32'(m), 32'(v.mant));
    chk($sformatf("%s %h class", tag, v.data), 32'(c), 32'(v.cls));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " s1 in_ready"}, 32'(in_ready1), 0);
    chk({tag, " s1 out_valid"}, 32'(out_valid1), 0);
    chk({tag, " s1 fields"}, 32'({out_sign1, out_exp1, out_mant1, out_class1}), 0);
    chk({tag, " s8 in_ready"}, 32'(in_ready8), 0);
    chk({tag, " s8 out_valid"}, 32'(out_valid8), 0);
    chk({tag, " s8 fields"}, 32'({out_sign8, out_exp8, out_mant8, out_class8}), 0);
  endtask

  // Apply one operand to both instances, measure latency, check result, then release it.
  task automatic run_vec(input vec_t v);
    int lat1, lat8;
    @(negedge clk);
    chk($sformatf("s1 %h in_ready before", v.data), 32'(in_ready1), 1);
    chk($sformatf("s8 %h in_ready before", v.data), 32'(in_ready8), 1);
    in_valid  = 1'b1;
    in_data   = v.data;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    lat1 = 0;
    lat8 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (lat1 == 0 && out_valid1) lat1 = c;
      if (lat8 == 0 && out_valid8) lat8 = c;
      if (lat1 != 0 && lat8 != 0) break;
      @(posedge clk);
      #1;
    end
    chk($sformatf("s1 %h latency", v.data), 32'(lat1), 32'(v.lat1));
    chk($sformatf("s8 %h latency", v.data), 32'(lat8), 32'(v.lat8));
    chk_out("s1", out_sign1, out_exp1, out_mant1, out_class1, v);
    chk_out("s8", out_sign8, out_exp8, out_mant8, out_class8, v);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("s1 %h released", v.data), 32'({out_valid1, in_ready1}), 32'(2'b01));
    chk($sformatf("s8 %h released", v.data), 32'({out_valid8, in_ready8}), 32'(2'b01));
  endtask

  initial begin
    int xfer1, xfer8;

    vecs[0]  = '{32'h3F800000, 0, 0,    'h800000, 2, 1, 1};
    vecs[1]  = '{32'hFF800000, 1, 128,  'h000000, 3, 1, 1};
    vecs[2]  = '{32'h7FC00001, 0, 128,  'h400001, 4, 1, 1};
    vecs[3]  = '{32'h7F800001, 0, 128,  'h000001, 5, 1, 1};
    vecs[4]  = '{32'h80000000, 1, 0,    'h000000, 0, 1, 1};
    vecs[5]  = '{32'hC0490FDB, 1, 1,    'hC90FDB, 2, 1, 1};
    vecs[6]  = '{32'h7F7FFFFF, 0, 127,  'hFFFFFF, 2, 1, 1};
    vecs[7]  = '{32'h00800000, 0, -126, 'h800000, 2, 1, 1};
`ifdef FP32_UNPACK_DAZ_EN
    vecs[8]  = '{32'h00000001, 0, 0,    'h000000, 0, 1, 1};
    vecs[9]  = '{32'h00400000, 0, 0,    'h000000, 0, 1, 1};
    vecs[10] = '{32'h00000003, 0, 0,    'h000000, 0, 1, 1};
    vecs[11] = '{32'h807FFFFF, 1, 0,    'h000000, 0, 1, 1};
`else
    vecs[8]  = '{32'h00000001, 0, -149, 'h800000, 1, 24, 4};
    vecs[9]  = '{32'h00400000, 0, -127, 'h800000, 1, 2, 2};
    vecs[10] = '{32'h00000003, 0, -148, 'hC00000, 1, 23, 4};
    vecs[11] = '{32'h807FFFFF, 1, -127, 'hFFFFFE, 1, 2, 2};
`endif

    // Reset state and release.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("s1 in_ready after reset", 32'(in_ready1), 1);
    chk("s8 in_ready after reset", 32'(in_ready8), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Downstream stall: result must hold for 5 cycles, new input ignored, single transfer.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    @(posedge clk);
    #1;
    in_data = 32'h7F800001;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall %0d s1 valid/ready", k), 32'({out_valid1, in_ready1}), 32'(2'b10));
      chk($sformatf("stall %0d s8 valid/ready", k), 32'({out_valid8, in_ready8}), 32'(2'b10));
      chk($sformatf("stall %0d s1 payload", k), 32'({out_sign1, out_exp1, out_mant1, out_class1}),
          32'({1'b0, 10'd0, 24'h800000, 3'd2}));
      chk($sformatf("stall %0d s8 class", k), 32'(out_class8), 2);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    xfer1 = 0;
    xfer8 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid1) xfer1++;
      if (out_valid8) xfer8++;
      @(posedge clk);
    end
    #1 out_ready = 1'b0;
    chk("stall s1 transfers", 32'(xfer1), 1);
    chk("stall s8 transfers", 32'(xfer8), 1);

    // Reset mid-NORM (s1) and mid-HOLD (s8) must drop the operand at once.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset s1 still normalizing", 32'({out_valid1, in_ready1}), 0);
    chk("pre-reset s8 holding", 32'(out_valid8), 1);
    #1 rst = 1'b1;
    #1;
    chk_zero("mid-op reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("s1 in_ready after mid reset", 32'({out_valid1, in_ready1}), 1);
    chk("s8 in_ready after mid reset", 32'({out_valid8, in_ready8}), 1);
    run_vec(vecs[0]);
    run_vec(vecs[8]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
